// File: rtl/rsp_uart_tx.sv
// Snoops Wishbone read completions and serialises each returned data byte onto a UART line (8N1, LSB first)
// through a small response FIFO.
module rsp_uart_tx #(
  parameter int unsigned BAUD_DIV = 434,
  parameter int unsigned DEPTH    = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   stb_i,
  input  logic                   we_i,
  input  logic                   ack_i,
  input  logic [7:0]             dat_i,
  output logic                   dout,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned CW = 16;
  localparam logic [CW-1:0] BAUD_RELOAD = CW'(BAUD_DIV - 1);
  localparam logic [LW-1:0] FULL_LEVEL  = LW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  baud_q, baud_d;
  logic [2:0]     bit_q, bit_d;
  logic [7:0]     shreg_q, shreg_d;
  logic           dout_d, busy_d;

  logic [7:0]     mem [DEPTH];
  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic           done_q;

  logic           cpl_c, push_req_c, pop_c, push_ok_c;

  // One push per read transaction; done_q blocks repeats until stb_i drops.
  assign cpl_c      = stb_i & ~we_i & ack_i;
  assign push_req_c = cpl_c & ~done_q;
  assign pop_c      = (state_q == IDLE) && (level != '0);
  assign push_ok_c  = push_req_c && ((level < FULL_LEVEL) || pop_c);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      done_q <= 1'b0;
    end else if (!stb_i) begin
      done_q <= 1'b0;
    end else if (push_req_c) begin
      done_q <= 1'b1;
    end
  end

  // FIFO pointers, occupancy and sticky overflow.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok_c) wr_ptr <= wr_ptr + AW'(1);
      if (pop_c)     rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok_c, pop_c})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
      if (push_req_c && !push_ok_c) overflow <= 1'b1;
    end
  end

  // Storage needs no reset; pointers define validity.
  always_ff @(posedge clk_i) begin
    if (push_ok_c) mem[wr_ptr] <= dat_i;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      dout    <= 1'b1;
      busy    <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      dout    <= dout_d;
      busy    <= busy_d;
    end
  end

  // Next-state logic; dout/busy are decoded from the next state so the registers line up with it.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    dout_d  = 1'b1;
    busy_d  = 1'b1;

    case (state_q)
      IDLE: begin
        if (pop_c) begin
          shreg_d = mem[rd_ptr];
          baud_d  = BAUD_RELOAD;
          bit_d   = 3'd0;
          state_d = START;
        end
      end
      START: begin
        if (baud_q == '0) begin
          baud_d  = BAUD_RELOAD;
          bit_d   = 3'd0;
          state_d = DATA;
        end else begin
          baud_d = baud_q - CW'(1);
        end
      end
      DATA: begin
        if (baud_q == '0) begin
          baud_d = BAUD_RELOAD;
          if (bit_q == 3'd7) begin
            state_d = STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          baud_d = baud_q - CW'(1);
        end
      end
      STOP: begin
        if (baud_q == '0) begin
          state_d = IDLE;
        end else begin
          baud_d = baud_q - CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    case (state_d)
      IDLE:    busy_d = 1'b0;
      START:   dout_d = 1'b0;
      DATA:    dout_d = shreg_d[bit_d];
      default: dout_d = 1'b1;
    endcase
  end

endmodule
